// File: rtl/shot_keeper_mp_if.sv
// Trigger/hit inputs and shot/hit count outputs of the multi-player shot keeper.
// CNT_W follows from MAX_SHOTS so the bus always matches the keeper's counters.
interface shot_keeper_mp_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_SHOTS   = 3
);
  localparam int CNT_W = $clog2(MAX_SHOTS + 1);

  logic [NUM_PLAYERS-1:0]       trigger;
  logic [NUM_PLAYERS-1:0]       hit;
  logic [2:0]                   state;
  logic                         round_start;
  logic [NUM_PLAYERS-1:0]       shot_fire;
  logic [NUM_PLAYERS*CNT_W-1:0] shots_used;
  logic [NUM_PLAYERS*CNT_W-1:0] hits;
  logic [NUM_PLAYERS-1:0]       no_shots_left;
  logic                         all_out;

  modport master (
    output trigger, hit, state, round_start,
    input  shot_fire, shots_used, hits, no_shots_left, all_out
  );

  modport slave (
    input  trigger, hit, state, round_start,
    output shot_fire, shots_used, hits, no_shots_left, all_out
  );
endinterface

// File: rtl/shot_keeper_mp.sv
// Per-player shot/hit keeper with round shot limit and refire cooldown.
// Raw trigger to shot_fire: 3 clock edges; no backpressure, dropped edges are not queued.
module shot_keeper_mp #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         MAX_SHOTS   = 3,
  parameter int         COOLDOWN    = 4,
  parameter logic [2:0] PLAY_STATE  = 3'b010
) (
  input logic           Clk,
  input logic           Reset_n,
  shot_keeper_mp_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_SHOTS + 1);
  localparam int TMR_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_SHOTS);
  localparam logic [TMR_W-1:0] TMR_LOAD = (COOLDOWN > 0) ? TMR_W'(COOLDOWN - 1) : '0;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    COOL  = 2'd1,
    EMPTY = 2'd2
  } pstate_t;

  logic [NUM_PLAYERS-1:0] s1, s2, s3;
  logic [NUM_PLAYERS-1:0] trig_edge;
  logic                   play;

  pstate_t          st_q  [NUM_PLAYERS];
  pstate_t          st_d  [NUM_PLAYERS];
  logic [CNT_W-1:0] cnt_q [NUM_PLAYERS];
  logic [CNT_W-1:0] cnt_d [NUM_PLAYERS];
  logic [CNT_W-1:0] hit_q [NUM_PLAYERS];
  logic [CNT_W-1:0] hit_d [NUM_PLAYERS];
  logic [TMR_W-1:0] tmr_q [NUM_PLAYERS];
  logic [TMR_W-1:0] tmr_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] pend_q, pend_d;
  logic [NUM_PLAYERS-1:0] fire_q, fire_d;
  logic [NUM_PLAYERS-1:0] nsl;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= bus.trigger;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign trig_edge = s2 & ~s3;
  assign play      = (bus.state == PLAY_STATE);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    hit_d  = hit_q;
    tmr_d  = tmr_q;
    pend_d = pend_q;
    fire_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.round_start) begin
        st_d[i]   = ARMED;
        cnt_d[i]  = '0;
        hit_d[i]  = '0;
        tmr_d[i]  = '0;
        pend_d[i] = 1'b0;
      end else begin
        // Hit is resolved before the shot so a same-cycle shot re-arms pending.
        if (bus.hit[i] && pend_q[i]) begin
          hit_d[i]  = hit_q[i] + 1'b1;
          pend_d[i] = 1'b0;
        end
        case (st_q[i])
          ARMED: begin
            if (trig_edge[i] && play) begin
              fire_d[i] = 1'b1;
              cnt_d[i]  = cnt_q[i] + 1'b1;
              pend_d[i] = 1'b1;
              if (cnt_q[i] + 1'b1 == MAX_C) begin
                st_d[i] = EMPTY;
              end else if (COOLDOWN > 0) begin
                st_d[i]  = COOL;
                tmr_d[i] = TMR_LOAD;
              end
            end
          end
          COOL: begin
            if (tmr_q[i] == '0) st_d[i] = ARMED;
            else                tmr_d[i] = tmr_q[i] - 1'b1;
          end
          EMPTY:   st_d[i] = EMPTY;
          default: st_d[i] = ARMED;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        st_q[i]  <= ARMED;
        cnt_q[i] <= '0;
        hit_q[i] <= '0;
        tmr_q[i] <= '0;
      end
      pend_q <= '0;
      fire_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      fire_q <= fire_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_out
    assign bus.shots_used[g*CNT_W +: CNT_W] = cnt_q[g];
    assign bus.hits[g*CNT_W +: CNT_W]       = hit_q[g];
    assign nsl[g]                           = (cnt_q[g] == MAX_C);
  end

  assign bus.shot_fire     = fire_q;
  assign bus.no_shots_left = nsl;
  assign bus.all_out       = &nsl;
endmodule

// File: tb/tb_shot_keeper_mp.sv
// Bench for shot_keeper_mp: directed scenarios plus random traffic against a
// model built from shot spacing, limits and pending-hit rules.
module tb_shot_keeper_mp;
  localparam int NP = 2;
  localparam int MS = 3;
  localparam int CD = 4;
  localparam logic [2:0] PS = 3'b010;
  localparam int CW = $clog2(MS + 1);
  localparam int VW = 2*NP + 2*NP*CW + 1;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  shot_keeper_mp_if #(.NUM_PLAYERS(NP), .MAX_SHOTS(MS)) bus ();

  shot_keeper_mp #(
    .NUM_PLAYERS(NP), .MAX_SHOTS(MS), .COOLDOWN(CD), .PLAY_STATE(PS)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  int m_cnt [NP];
  int m_hits[NP];
  int m_last[NP];
  bit m_pend[NP];
  bit m_fire[NP];
  logic [NP-1:0] th[$];
  int cyc;

  logic [VW-1:0] dutv;
  assign dutv = {bus.shot_fire, bus.shots_used, bus.hits, bus.no_shots_left, bus.all_out};

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_cnt[p] = 0; m_hits[p] = 0; m_last[p] = -1000; m_pend[p] = 0; m_fire[p] = 0;
    end
    th.delete();
    repeat (3) th.push_back('0);
    cyc = 0;
  endfunction

  function automatic logic [VW-1:0] expv();
    logic [NP-1:0] f, n;
    logic [NP*CW-1:0] u, h;
    for (int p = 0; p < NP; p++) begin
      f[p] = m_fire[p];
      u[p*CW +: CW] = CW'(m_cnt[p]);
      h[p*CW +: CW] = CW'(m_hits[p]);
      n[p] = (m_cnt[p] == MS);
    end
    return {f, u, h, n, &n};
  endfunction

  // Drives one cycle of inputs, advances the model at the edge, returns 1 time unit after it.
  task automatic step(input logic [NP-1:0] tr, input logic [NP-1:0] hi,
                      input logic [2:0] st, input logic rs);
    logic [NP-1:0] edges;
    bus.trigger = tr; bus.hit = hi; bus.state = st; bus.round_start = rs;
    @(posedge Clk);
    cyc++;
    // A trigger sampled at edge n becomes a usable rising edge at edge n+2.
    edges = th[th.size()-2] & ~th[th.size()-3];
    th.push_back(tr);
    if (th.size() > 8) void'(th.pop_front());
    for (int p = 0; p < NP; p++) begin
      m_fire[p] = 0;
      if (rs) begin
        m_cnt[p] = 0; m_hits[p] = 0; m_pend[p] = 0; m_last[p] = -1000;
      end else begin
        if (hi[p] && m_pend[p]) begin
          m_hits[p]++;
          m_pend[p] = 0;
        end
        if (edges[p] && st == PS && m_cnt[p] < MS && (cyc - m_last[p]) >= CD + 1) begin
          m_cnt[p]++;
          m_pend[p] = 1;
          m_fire[p] = 1;
          m_last[p] = cyc;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    bus.trigger = '0; bus.hit = '0; bus.state = PS; bus.round_start = 1'b0;
    Reset_n = 1'b0;
    #3;
    checks++;
    if (dutv !== '0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0", dutv);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_latency();
    int nf = 0;
    int fidx = -1;
    for (int s = 0; s < 14; s++) begin
      step((s < 10) ? 2'b01 : 2'b00, '0, PS, 1'b0);
      checks++;
      if (dutv !== expv()) begin
        failures++;
        $display("FAIL latency step %0d: got %h expected %h", s, dutv, expv());
      end
      if (bus.shot_fire[0]) begin nf++; if (fidx < 0) fidx = s; end
    end
    checks++;
    if (nf !== 1 || fidx !== 2) begin
      failures++;
      $display("FAIL latency_pulse: got %0d pulses at step %0d expected 1 at step 2", nf, fidx);
    end
    checks++;
    if (bus.shots_used !== {CW'(0), CW'(1)}) begin
      failures++;
      $display("FAIL latency_counts: got %h expected %h", bus.shots_used, {CW'(0), CW'(1)});
    end
  endtask

  task automatic test_limit();
    int nf = 0;
    step('0, '0, PS, 1'b1);
    for (int s = 0; s < 40; s++) begin
      step(((s % 8) < 2) ? 2'b01 : 2'b00, '0, PS, 1'b0);
      checks++;
      if (dutv !== expv()) begin
        failures++;
        $display("FAIL limit step %0d: got %h expected %h", s, dutv, expv());
      end
      if (bus.shot_fire[0]) nf++;
    end
    checks++;
    if (nf !== 3 || bus.shots_used[CW-1:0] !== CW'(3) || bus.no_shots_left[0] !== 1'b1) begin
      failures++;
      $display("FAIL limit_final: pulses=%0d count=%0d empty=%b expected 3 3 1",
               nf, bus.shots_used[CW-1:0], bus.no_shots_left[0]);
    end
  endtask

  task automatic test_cooldown();
    int nf = 0;
    step('0, '0, PS, 1'b1);
    for (int s = 0; s < 14; s++) begin
      step((s < 8 && (s % 2) == 0) ? 2'b10 : 2'b00, '0, PS, 1'b0);
      checks++;
      if (dutv !== expv()) begin
        failures++;
        $display("FAIL cooldown step %0d: got %h expected %h", s, dutv, expv());
      end
      if (bus.shot_fire[1]) nf++;
    end
    checks++;
    if (nf !== 2 || bus.shots_used[CW +: CW] !== CW'(2)) begin
      failures++;
      $display("FAIL cooldown_final: pulses=%0d count=%0d expected 2 2", nf, bus.shots_used[CW +: CW]);
    end
  endtask

  task automatic test_gating_simul();
    int gated = 0;
    int both = 0;
    step('0, '0, PS, 1'b1);
    for (int s = 0; s < 15; s++) begin
      if (s < 7) step((s < 4) ? 2'b11 : 2'b00, '0, 3'b001, 1'b0);
      else       step((s < 11) ? 2'b11 : 2'b00, '0, PS, 1'b0);
      checks++;
      if (dutv !== expv()) begin
        failures++;
        $display("FAIL gating step %0d: got %h expected %h", s, dutv, expv());
      end
      if (s < 7 && bus.shot_fire !== '0) gated++;
      if (bus.shot_fire === 2'b11) both++;
    end
    checks++;
    if (gated !== 0 || both !== 1 || bus.shots_used !== {CW'(1), CW'(1)}) begin
      failures++;
      $display("FAIL gating_final: gated=%0d joint=%0d counts=%h expected 0 1 %h",
               gated, both, bus.shots_used, {CW'(1), CW'(1)});
    end
  endtask

  task automatic test_hits();
    step('0, '0, PS, 1'b1);
    for (int s = 0; s < 26; s++) begin
      logic [NP-1:0] hv;
      hv = '0;
      hv[0] = (s == 4 || s == 6 || s == 18 || s == 22);
      hv[1] = (s == 5 || s == 12);
      step(((s % 8) == 0 && s < 24) ? 2'b01 : 2'b00, hv, PS, 1'b0);
      checks++;
      if (dutv !== expv()) begin
        failures++;
        $display("FAIL hits step %0d: got %h expected %h", s, dutv, expv());
      end
      if (s == 7 || s == 18 || s == 25) begin
        int want;
        want = (s == 7) ? 1 : (s == 18) ? 2 : 3;
        checks++;
        if (bus.hits[CW-1:0] !== CW'(want)) begin
          failures++;
          $display("FAIL hits_count step %0d: got %0d expected %0d", s, bus.hits[CW-1:0], want);
        end
      end
    end
    checks++;
    if (bus.hits[CW +: CW] !== '0) begin
      failures++;
      $display("FAIL hits_unpending: got %0d expected 0", bus.hits[CW +: CW]);
    end
  endtask

  task automatic test_reload_reset();
    step('0, '0, PS, 1'b1);
    for (int s = 0; s < 24; s++) begin
      step(((s % 8) == 0) ? 2'b11 : 2'b00, '0, PS, 1'b0);
      checks++;
      if (dutv !== expv()) begin
        failures++;
        $display("FAIL reload_fill step %0d: got %h expected %h", s, dutv, expv());
      end
    end
    checks++;
    if (bus.all_out !== 1'b1) begin
      failures++;
      $display("FAIL reload_all_out: got %b expected 1", bus.all_out);
    end
    step(2'b11, '0, PS, 1'b0);
    step(2'b11, '0, PS, 1'b0);
    step(2'b11, '0, PS, 1'b1);
    checks++;
    if (dutv !== '0 || dutv !== expv()) begin
      failures++;
      $display("FAIL reload_clear: got %h expected 0", dutv);
    end
    for (int s = 0; s < 7; s++) begin
      step((s == 3) ? 2'b01 : 2'b00, '0, PS, 1'b0);
      checks++;
      if (dutv !== expv()) begin
        failures++;
        $display("FAIL reload_refire step %0d: got %h expected %h", s, dutv, expv());
      end
    end
    Reset_n = 1'b0;
    #2;
    checks++;
    if (dutv !== '0) begin
      failures++;
      $display("FAIL async_reset: got %h expected 0", dutv);
    end
    bus.trigger = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_random();
    logic [NP-1:0] tr;
    tr = '0;
    step('0, '0, PS, 1'b1);
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 2) == 0) tr = NP'($urandom);
      step(tr, NP'($urandom), ($urandom_range(0, 7) == 0) ? 3'b001 : PS,
           ($urandom_range(0, 49) == 0));
      checks++;
      if (dutv !== expv()) begin
        failures++;
        $display("FAIL random step %0d: got %h expected %h", s, dutv, expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_limit();
    test_cooldown();
    test_gating_simul();
    test_hits();
    test_reload_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shot_keeper_mp.md
Name: shot_keeper_mp

Overview:
- Parametrised, multi-player successor to the single-player shot counter.
- Tracks shots fired and hits landed per player during a round, and enforces the per-round shot limit and a refire cooldown.
- Synchronises raw trigger inputs internally.
- Feeds the game FSM (empty/all-out flags) and the score/HUD logic (counts and a fire pulse).

Parameters:
- NUM_PLAYERS, 2, number of independent trigger channels (1..8).
- MAX_SHOTS, 3, shots allowed per player per round (1..255).
- COOLDOWN, 4, minimum cycles between accepted shots of one player (0 = none).
- PLAY_STATE, 3'b010, game-FSM state code in which shots are accepted.
- CNT_W, $clog2(MAX_SHOTS+1), width of each per-player counter (derived; not overridden).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- trigger  in  NUM_PLAYERS  raw, asynchronous trigger level per player
- hit  in  NUM_PLAYERS  one-cycle hit-confirm pulse from the hit detector, synchronous to Clk
- state  in  3  current game-FSM state
- round_start  in  1  one-cycle pulse that reloads all players
- shot_fire  out  NUM_PLAYERS  one-cycle pulse per accepted shot
- shots_used  out  NUM_PLAYERS*CNT_W  packed shot counts; player i at [i*CNT_W +: CNT_W]
- hits  out  NUM_PLAYERS*CNT_W  packed hit counts, same packing
- no_shots_left  out  NUM_PLAYERS  player has reached MAX_SHOTS
- all_out  out  1  AND of no_shots_left

Behaviour:
- Reset (Reset_n low, asynchronous): all sync flops, counters, pending flags and cooldown timers clear to 0. Every player goes to ARMED. shot_fire=0, shots_used=0, hits=0, no_shots_left=0, all_out=0. Reset asserted mid-round discards all state immediately.
- Synchroniser, per player: s1<=trigger, s2<=s1, s3<=s2. The edge is s2 & ~s3.
- Fire latency: trigger first sampled high at posedge k -> shot_fire high and shots_used incremented after posedge k+2. A held trigger fires once.
- Per-player FSM:
  - ARMED: if edge && state==PLAY_STATE && !round_start, then:
    - shot_fire<=1, count<=count+1, pending<=1;
    - next state is EMPTY if count+1==MAX_SHOTS, else COOLDOWN if COOLDOWN>0, else ARMED.
  - COOLDOWN: timer loads COOLDOWN-1 on entry and decrements each cycle; state becomes ARMED when the timer reaches 0.
    - Edges during COOLDOWN are dropped, not queued.
    - The timer keeps running when state leaves PLAY_STATE.
  - EMPTY: edges are ignored. Leaves EMPTY only on round_start or reset.
  - Edges while state!=PLAY_STATE are dropped in every FSM state.
- Cooldown timing: accepted shots of one player are at least COOLDOWN+1 cycles apart.
- shot_fire is a registered pulse and is high for exactly one cycle per accepted shot.
- no_shots_left[i] = (count_i == MAX_SHOTS). It is combinational from the registered count. The count never exceeds MAX_SHOTS.
- Hits:
  - hit[i] is counted (hits_i+1) only when pending_i==1; a counted hit clears pending_i.
  - A hit with pending==0 is ignored.
  - A new accepted shot sets pending again. An unhit earlier shot is simply overwritten.
  - hits_i <= shots_used_i always holds.
- Simultaneous hit[i] and accepted shot for player i in the same cycle: the hit credits the old pending shot, and pending stays 1 for the new shot.
- round_start (synchronous, highest priority after reset): clears all counts, hits, pending flags and cooldown timers; all players go to ARMED. A shot edge in the same cycle is dropped, and a hit in the same cycle is dropped.
- Players are fully independent. Simultaneous edges from all players are all accepted in the same cycle.
- all_out = &no_shots_left. With NUM_PLAYERS=1 it equals no_shots_left[0].

Test Plan:
- Reset/latency: Reset_n low then high, state=3'b010, trigger[0] high 10 cycles -> one shot_fire[0] pulse 3 edges after first sample, shots_used[0]=1, player 1 unchanged.
- Limit: MAX_SHOTS=3, COOLDOWN=4, trigger[0] pulsed every 8 cycles x5 -> exactly 3 shot_fire pulses, no_shots_left[0]=1 after the 3rd, pulses 4-5 ignored, count stays 3.
- Cooldown: trigger[1] edges spaced 2 cycles apart x4 -> only edges landing >=5 cycles after the previous accepted shot fire; shots_used[1]=2.
- State gating and simultaneity: state=3'b001 with triggers -> no fire. Then state=3'b010 with both players rising the same cycle -> both shot_fire bits pulse together, both counts 1.
- Hits: shot then hit[0] twice -> hits[0]=1. A hit with no pending shot -> ignored. Hit in the same cycle as the 2nd shot -> hits[0]=2, pending=1.
- Round reload and async reset: both players at 3 shots, all_out=1. round_start coincident with a trigger edge -> all counts 0, all_out=0, no fire. Then Reset_n pulsed low mid-cooldown -> outputs 0 immediately, without waiting for a clock edge.
